// File: rtl/bp_be_stride_prefetcher_pkg.sv
// Shared types and constants for the backend stride prefetcher.
// Processor config lookup, request bundle, FSM states, line offset width.
package bp_be_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg
  } bp_params_e;

  localparam int bp_vaddr_width_gp       = 39;
  localparam int bp_dcache_block_width_gp = 512;

  function automatic int bp_vaddr_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return bp_vaddr_width_gp;
      default:          return bp_vaddr_width_gp;
    endcase
  endfunction

  localparam int bp_be_pf_line_offset_gp =
    $clog2(bp_dcache_block_width_gp / 8);

  typedef struct packed {
    logic [bp_vaddr_width_gp-1:0] addr;
    logic [bp_vaddr_width_gp-1:0] pc;
  } bp_be_pf_req_s;

  typedef enum logic [0:0] {
    e_idle,
    e_gen
  } bp_be_pf_state_e;

endpackage

// File: rtl/bp_be_stride_prefetcher_if.sv
// Prefetch request channel from the stride prefetcher to the dcache.
// Valid/ready handshake carrying a line address and originating PC.
interface bp_be_stride_prefetcher_if
  import bp_be_pkg::*;
  #(parameter int vaddr_width_p = bp_vaddr_width_gp);

  logic                     pf_v_o;
  logic [vaddr_width_p-1:0] pf_addr_o;
  logic [vaddr_width_p-1:0] pf_pc_o;
  logic                     pf_ready_i;

  modport master (
    output pf_v_o,
    output pf_addr_o,
    output pf_pc_o,
    input  pf_ready_i
  );

  modport slave (
    input  pf_v_o,
    input  pf_addr_o,
    input  pf_pc_o,
    output pf_ready_i
  );

endinterface

// File: rtl/bp_be_stride_prefetcher_line_filter.sv
// Recent-line CAM: remembers the last few enqueued prefetch lines.
// FIFO replacement; clear and reset invalidate every entry.
module bp_be_pf_line_filter #(
  parameter int els_p   = 4,
  parameter int width_p = 39
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clr_i,
  input  logic               w_v_i,
  input  logic [width_p-1:0] w_addr_i,
  input  logic [width_p-1:0] r_addr_i,
  output logic               hit_o
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;

  logic [width_p-1:0]  tag_q [els_p];
  logic [width_p-1:0]  tag_d [els_p];
  logic [els_p-1:0]    v_q, v_d;
  logic [ptr_w_lp-1:0] ptr_q, ptr_d;

  // Associative lookup across valid entries.
  always_comb begin
    hit_o = 1'b0;
    for (int i = 0; i < els_p; i++)
      hit_o = hit_o | (v_q[i] & (tag_q[i] == r_addr_i));
  end

  // Install at the replacement pointer; clear wipes valids.
  always_comb begin
    tag_d = tag_q;
    v_d   = v_q;
    ptr_d = ptr_q;
    if (w_v_i) begin
      tag_d[ptr_q] = w_addr_i;
      v_d[ptr_q]   = 1'b1;
      ptr_d = (ptr_q == ptr_w_lp'(els_p - 1))
            ? '0 : ptr_q + 1'b1;
    end
    if (clr_i) begin
      v_d   = '0;
      ptr_d = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_q   <= '0;
      ptr_q <= '0;
      for (int i = 0; i < els_p; i++)
        tag_q[i] <= '0;
    end else begin
      v_q   <= v_d;
      ptr_q <= ptr_d;
      tag_q <= tag_d;
    end
  end

endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// Small flop-based FIFO with registered storage and a synchronous clear.
// A full FIFO accepts an enqueue in the same cycle as a dequeue.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clr_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = $clog2(els_p);

  logic [ptr_w_lp:0]  wptr_q, wptr_d;
  logic [ptr_w_lp:0]  rptr_q, rptr_d;
  logic [width_p-1:0] mem_q [els_p];
  logic [width_p-1:0] mem_d [els_p];
  logic full, empty, enq, deq;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[ptr_w_lp] != rptr_q[ptr_w_lp])
               & (wptr_q[ptr_w_lp-1:0] == rptr_q[ptr_w_lp-1:0]);

  assign ready_o = ~full | yumi_i;
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & ~empty;
  assign v_o     = ~empty;
  assign data_o  = mem_q[rptr_q[ptr_w_lp-1:0]];

  // Pointer and storage next-state; clear drops all entries.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    mem_d  = mem_q;
    if (enq) begin
      mem_d[wptr_q[ptr_w_lp-1:0]] = data_i;
      wptr_d = wptr_q + 1'b1;
    end
    if (deq)
      rptr_d = rptr_q + 1'b1;
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < els_p; i++)
        mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/bp_be_stride_prefetcher.sv
// Stride prefetcher: turns RPT stride detections into line prefetches.
// Optional recent-line CAM filter enabled by BP_BE_PF_FILTER_EN.
module bp_be_stride_prefetcher
  import bp_be_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int stride_width_p = 8,
  parameter int degree_p       = 4,
  parameter int fifo_els_p     = 4,
  parameter int filter_els_p   = 4,
  localparam int vaddr_width_p = bp_vaddr_width(bp_params_p),
  localparam int cnt_w_lp      = $clog2(degree_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      stride_v_i,
  input  logic [vaddr_width_p-1:0]  eff_addr_i,
  input  logic [stride_width_p-1:0] stride_i,
  input  logic [vaddr_width_p-1:0]  pc_i,
  input  logic                      start_discovery_i,
  input  logic                      confirm_discovery_i,
  input  logic                      flush_i,
  bp_be_stride_prefetcher_if.master pf_if,
  output logic                      confirmed_o,
  output logic                      busy_o
);

  localparam int off_lp = bp_be_pf_line_offset_gp;
  localparam logic [vaddr_width_p-1:0] line_mask_lp =
    {{(vaddr_width_p-off_lp){1'b1}}, {off_lp{1'b0}}};

  bp_be_pf_state_e state_q, state_d;
  logic [vaddr_width_p-1:0] base_q, base_d;
  logic [vaddr_width_p-1:0] acc_q, acc_d;
  logic [vaddr_width_p-1:0] step_q, step_d;
  logic [vaddr_width_p-1:0] pc_q, pc_d;
  logic [vaddr_width_p-1:0] last_q, last_d;
  logic                     last_v_q, last_v_d;
  logic [cnt_w_lp-1:0]      k_q, k_d;
  logic [cnt_w_lp-1:0]      deg_q, deg_d;
  logic                     confirmed_q, confirmed_d;

  logic [vaddr_width_p-1:0] stride_ext, cand_line;
  logic trig_v, gen_act, skip, consume, filter_hit;
  logic fifo_v_li, fifo_ready_lo, fifo_v_lo;
  bp_be_pf_req_s fifo_req_li, fifo_req_lo;

  assign stride_ext = {{(vaddr_width_p-stride_width_p)
                        {stride_i[stride_width_p-1]}}, stride_i};
  assign cand_line  = (base_q + acc_q) & line_mask_lp;
  assign trig_v     = stride_v_i & (stride_i != '0) & ~flush_i;
  assign gen_act    = (state_q == e_gen) & ~flush_i & ~trig_v;
  assign skip       = (last_v_q & (cand_line == last_q)) | filter_hit;
  assign fifo_v_li  = gen_act & ~skip;
  assign consume    = gen_act & (skip | fifo_ready_lo);

`ifdef BP_BE_PF_FILTER_EN
  bp_be_pf_line_filter #(
    .els_p   (filter_els_p),
    .width_p (vaddr_width_p)
  ) filter (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clr_i     (flush_i),
    .w_v_i     (fifo_v_li & fifo_ready_lo),
    .w_addr_i  (cand_line),
    .r_addr_i  (cand_line),
    .hit_o     (filter_hit)
  );
`else
  localparam int unused_filter_els_lp = filter_els_p;
  assign filter_hit = 1'b0;
`endif

  // Mode register: flush beats confirm, confirm beats start.
  always_comb begin
    confirmed_d = confirmed_q;
    if (flush_i)
      confirmed_d = 1'b0;
    else if (confirm_discovery_i)
      confirmed_d = 1'b1;
    else if (start_discovery_i)
      confirmed_d = 1'b0;
  end

  // Generator next-state: walk k*step, reload on trigger, flush idles.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    acc_d    = acc_q;
    step_d   = step_q;
    pc_d     = pc_q;
    k_d      = k_q;
    deg_d    = deg_q;
    last_d   = last_q;
    last_v_d = last_v_q;
    unique case (state_q)
      e_idle: ;
      e_gen: begin
        if (consume) begin
          k_d   = k_q + 1'b1;
          acc_d = acc_q + step_q;
          if (k_q == deg_q)
            state_d = e_idle;
        end
      end
      default: state_d = e_idle;
    endcase
    if (consume & ~skip) begin
      last_d   = cand_line;
      last_v_d = 1'b1;
    end
    if (trig_v) begin
      state_d = e_gen;
      base_d  = eff_addr_i;
      step_d  = stride_ext;
      acc_d   = stride_ext;
      pc_d    = pc_i;
      k_d     = cnt_w_lp'(1);
      deg_d   = (confirm_discovery_i | confirmed_q)
              ? cnt_w_lp'(degree_p) : cnt_w_lp'(1);
    end
    if (flush_i) begin
      state_d  = e_idle;
      last_v_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= e_idle;
      base_q      <= '0;
      acc_q       <= '0;
      step_q      <= '0;
      pc_q        <= '0;
      k_q         <= '0;
      deg_q       <= '0;
      last_q      <= '0;
      last_v_q    <= 1'b0;
      confirmed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      acc_q       <= acc_d;
      step_q      <= step_d;
      pc_q        <= pc_d;
      k_q         <= k_d;
      deg_q       <= deg_d;
      last_q      <= last_d;
      last_v_q    <= last_v_d;
      confirmed_q <= confirmed_d;
    end
  end

  assign fifo_req_li.addr = cand_line;
  assign fifo_req_li.pc   = pc_q;

  bsg_fifo_1r1w_small #(
    .width_p ($bits(bp_be_pf_req_s)),
    .els_p   (fifo_els_p)
  ) req_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clr_i     (flush_i),
    .v_i       (fifo_v_li),
    .ready_o   (fifo_ready_lo),
    .data_i    (fifo_req_li),
    .v_o       (fifo_v_lo),
    .data_o    (fifo_req_lo),
    .yumi_i    (fifo_v_lo & pf_if.pf_ready_i)
  );

  assign pf_if.pf_v_o    = fifo_v_lo;
  assign pf_if.pf_addr_o = fifo_req_lo.addr;
  assign pf_if.pf_pc_o   = fifo_req_lo.pc;
  assign confirmed_o     = confirmed_q;
  assign busy_o          = (state_q == e_gen) | fifo_v_lo;

endmodule
